// File: rtl/conv_layer_sequencer.sv
// Frame controller for one convolutional layer: streams pixels in, drains the pipeline,
// and holds each result in a single output register until downstream takes it.
module conv_layer_sequencer #(
  parameter int D_WIDTH      = 8,
  parameter int Q_WIDTH      = 16,
  parameter int D_CHANNELS   = 3,
  parameter int Q_CHANNELS   = 5,
  parameter int FILTER_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 32,
  parameter int DRAIN_MAX    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D_CHANNELS*D_WIDTH-1:0] in_data,
  output logic                         conv_clk_en,
  output logic [D_CHANNELS*D_WIDTH-1:0] conv_din,
  input  logic [Q_CHANNELS*Q_WIDTH-1:0] conv_dout,
  input  logic                         conv_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [Q_CHANNELS*Q_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int N_IN  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int N_OUT = (IMAGE_WIDTH - FILTER_SIZE + 1) * (IMAGE_HEIGHT - FILTER_SIZE + 1);
  localparam int ICW   = $clog2(N_IN + 1);
  localparam int OCW   = $clog2(N_OUT + 1);
  localparam int DCW   = $clog2(DRAIN_MAX + 1);

  localparam logic [ICW-1:0] IN_LAST    = ICW'(N_IN - 1);
  localparam logic [OCW-1:0] OUT_LAST   = OCW'(N_OUT - 1);
  localparam logic [OCW-1:0] OUT_END    = OCW'(N_OUT);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [ICW-1:0] in_cnt;
  logic [OCW-1:0] out_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           fresh;
  logic           out_free;
  logic           fresh_blocked;
  logic           capture;
  logic           accept;
  logic           timeout;
  logic           start_frame;

  assign out_free      = !out_valid || out_ready;
  assign fresh_blocked = fresh && !out_free;
  // Each layer output is examined exactly once; extra results past N_OUT are dropped.
  assign capture = fresh && conv_valid && out_free && (out_cnt != OUT_END) &&
                   (state == STREAM || state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    in_ready    = 1'b0;
    accept      = 1'b0;
    conv_clk_en = 1'b0;
    conv_din    = '0;
    timeout     = 1'b0;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          state_nxt   = STREAM;
        end
      end
      STREAM: begin
        in_ready    = out_free && !fresh_blocked;
        accept      = in_valid && in_ready;
        conv_clk_en = accept;
        conv_din    = accept ? in_data : '0;
        if (accept && in_cnt == IN_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        conv_clk_en = out_free;
        if ((capture && out_cnt == OUT_LAST) || out_cnt == OUT_END) begin
          state_nxt = DONE;
        end else if (conv_clk_en && drain_cnt == DRAIN_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
      fresh     <= 1'b0;
      err       <= 1'b0;
    end else if (start_frame) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
      fresh     <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept)  in_cnt  <= in_cnt + ICW'(1);
      if (capture) out_cnt <= out_cnt + OCW'(1);
      if (state == DRAIN && conv_clk_en) drain_cnt <= drain_cnt + DCW'(1);
      fresh <= conv_clk_en || (fresh && !out_free);
      if (timeout) err <= 1'b1;
    end
  end

  // Capture and downstream take on the same edge replace the entry without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_last  <= (out_cnt == OUT_LAST);
      out_data  <= conv_dout;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with a small pipelined stand-in for the layer.
module tb_conv_layer_sequencer;
  localparam int W = 64, H = 32, F = 5, OW = W - F + 1;
  localparam int N_IN = W * H, N_OUT = (W - F + 1) * (H - F + 1);
  localparam int DW = 24, QW = 80, LAT = 3;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic busy, done, err, in_ready, conv_clk_en, conv_valid, out_valid, out_last;
  logic [DW-1:0] conv_din;
  logic [QW-1:0] conv_dout, out_data;

  int n_cmp = 0, n_bad = 0;

  conv_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .conv_clk_en(conv_clk_en), .conv_din(conv_din), .conv_dout(conv_dout),
    .conv_valid(conv_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Layer stand-in: fixed-latency pipeline that only advances on conv_clk_en.
  logic [QW-1:0] md [LAT];
  logic          mv [LAT];
  int            m_cnt = 0;
  logic          model_clr = 1'b1, kill_valid = 1'b0;

  always @(posedge clk) begin
    if (model_clr) begin
      m_cnt <= 0;
      for (int i = 0; i < LAT; i++) mv[i] <= 1'b0;
    end else if (conv_clk_en) begin
      mv[0] <= (m_cnt < N_IN) && (m_cnt / W >= F - 1) && (m_cnt % W >= F - 1);
      md[0] <= {conv_din, 16'(m_cnt), 40'h00C0FFEE00};
      for (int i = 1; i < LAT; i++) begin
        mv[i] <= mv[i-1];
        md[i] <= md[i-1];
      end
      m_cnt <= m_cnt + 1;
    end
  end
  assign conv_valid = mv[LAT-1] && !kill_valid;
  assign conv_dout  = md[LAT-1];

  function automatic logic [DW-1:0] pix(input int p);
    return {8'(p), 8'(p >> 8), 8'(p * 3 + 1)};
  endfunction

  function automatic logic [QW-1:0] gold(input int j);
    int p;
    p = (F - 1 + j / OW) * W + (F - 1 + j % OW);
    return {pix(p), 16'(p), 40'h00C0FFEE00};
  endfunction

  task automatic run_frame(input int valid_pct, input int stall_at, input int start_at,
                           input int reset_at, output int acc, output int got,
                           output int dones, output int lasts, output int drain_en);
    int cyc = 0, stall_left = 0;
    bit acc_now = 1'b0, held_ok = 1'b0;
    logic [QW-1:0] held = '0;
    acc = 0; got = 0; dones = 0; lasts = 0; drain_en = 0;
    @(negedge clk);
    start = 1'b1; model_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; model_clr = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
    while (busy && cyc < 20000) begin
      if (acc_now) in_valid = 1'b0;
      acc_now = 1'b0;
      if (!in_valid) in_valid = (acc < N_IN) && ($urandom_range(99) < valid_pct);
      in_data = pix(acc);
      start = (cyc == start_at);
      if (cyc == stall_at) stall_left = 100;
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (acc < N_IN) begin
        n_cmp++;
        if (conv_clk_en !== (in_valid && in_ready)) begin
          n_bad++;
          $display("FAIL stream_clk_en: got %b want %b (acc %0d)", conv_clk_en, in_valid && in_ready, acc);
        end
      end else if (conv_clk_en) drain_en++;
      if (!out_ready && out_valid) begin
        n_cmp++;
        if (held_ok && out_data !== held) begin
          n_bad++; $display("FAIL stall_hold: got %h want %h", out_data, held);
        end
        n_cmp++;
        if (conv_clk_en !== 1'b0 || in_ready !== 1'b0) begin
          n_bad++; $display("FAIL stall_block: clk_en %b in_ready %b want 0 0", conv_clk_en, in_ready);
        end
        held = out_data; held_ok = 1'b1;
      end else held_ok = 1'b0;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (got >= N_OUT || out_data !== gold(got)) begin
          n_bad++; $display("FAIL result_%0d: got %h want %h", got, out_data, gold(got));
        end
        n_cmp++;
        if (out_last !== (got == N_OUT - 1)) begin
          n_bad++; $display("FAIL last_%0d: got %b want %b", got, out_last, got == N_OUT - 1);
        end
        if (out_last) lasts++;
        got++;
      end
      if (done) dones++;
      if (in_valid && in_ready) begin acc++; acc_now = 1'b1; end
      if (reset_at >= 0 && acc == reset_at) begin
        rst_n = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20000) begin
      n_cmp++; n_bad++; $display("FAIL frame_timeout: busy after %0d cycles", cyc);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int acc, input int got, input int dones,
                             input int lasts);
    n_cmp++;
    if (acc !== N_IN)  begin n_bad++; $display("FAIL %s accepts: got %0d want %0d", tag, acc, N_IN); end
    n_cmp++;
    if (got !== N_OUT) begin n_bad++; $display("FAIL %s results: got %0d want %0d", tag, got, N_OUT); end
    n_cmp++;
    if (lasts !== 1)   begin n_bad++; $display("FAIL %s last_count: got %0d want 1", tag, lasts); end
    n_cmp++;
    if (dones !== 1)   begin n_bad++; $display("FAIL %s done_count: got %0d want 1", tag, dones); end
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s end_state: err %b busy %b want 0 0", tag, err, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({busy, done, err, in_ready, conv_clk_en, out_valid, out_last} !== 7'b0) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b want 0000000", tag,
               {busy, done, err, in_ready, conv_clk_en, out_valid, out_last});
    end
    n_cmp++;
    if (out_data !== '0 || conv_din !== '0) begin
      n_bad++; $display("FAIL %s data: out %h din %h want 0", tag, out_data, conv_din);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; model_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy %b in_ready %b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_full_frame();
    int a, g, d, l, de;
    run_frame(100, -1, -1, -1, a, g, d, l, de);
    check_frame("full", a, g, d, l);
  endtask

  task automatic test_random_valid();
    int a, g, d, l, de;
    run_frame(50, -1, -1, -1, a, g, d, l, de);
    check_frame("random", a, g, d, l);
  endtask

  task automatic test_stall();
    int a, g, d, l, de;
    run_frame(100, 900, -1, -1, a, g, d, l, de);
    check_frame("stall", a, g, d, l);
  endtask

  task automatic test_back_to_back();
    int a, g, d, l, de;
    run_frame(100, -1, 500, -1, a, g, d, l, de);
    check_frame("start_ignored", a, g, d, l);
    run_frame(100, -1, -1, -1, a, g, d, l, de);
    check_frame("frame2", a, g, d, l);
  endtask

  task automatic test_reset_midframe();
    int a, g, d, l, de;
    run_frame(100, -1, -1, 1000, a, g, d, l, de);
    #1 check_all_zero("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(100, -1, -1, -1, a, g, d, l, de);
    check_frame("after_reset", a, g, d, l);
  endtask

  task automatic test_drain_timeout();
    int a, g, d, l, de;
    kill_valid = 1'b1;
    run_frame(100, -1, -1, -1, a, g, d, l, de);
    kill_valid = 1'b0;
    n_cmp++;
    if (de !== 64) begin n_bad++; $display("FAIL timeout_drain_cycles: got %0d want 64", de); end
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_state: err %b busy %b want 1 0", err, busy);
    end
    n_cmp++;
    if (d !== 0 || g !== 0) begin
      n_bad++; $display("FAIL timeout_outputs: done_count %0d results %0d want 0 0", d, g);
    end
    run_frame(100, -1, -1, -1, a, g, d, l, de);
    check_frame("after_timeout", a, g, d, l);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_valid();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_drain_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
